exec_ctrl: RTL

Multi-cycle execute-stage controller between the instruction decoder and the single-cycle `ALU` datapath. It accepts one decoded instruction at a time over a valid/ready handshake and maps the 37-bit one-hot instruction bus to an ALU operation and operand pair. It captures the ALU result and zero flag, evaluates branch conditions, and presents the result over a second valid/ready handshake. Shifts run serially inside the controller unless fast shift is compiled in.

---
 rtl/exec_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_ctrl.sv
// Execute-stage controller: one-hot decode, ALU issue, branch evaluation and a serial shifter.
// Define EXEC_FAST_SHIFT_EN to issue shifts to the ALU directly (no SHIFT state or counter).
module exec_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [36:0]     instr_bus,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD
`ifndef EXEC_FAST_SHIFT_EN
    , S_SHIFT
`endif
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_op;
  logic            r_bad, r_br, r_br_zero, r_br_inv;
  logic [XLEN-1:0] r_a, r_b;
  logic [XLEN-1:0] r_result;
  logic            r_taken, r_illegal;

  logic            w_onehot;
  logic [5:0]      w_idx;
  logic [3:0]      w_op;
  logic            w_use_imm, w_br, w_br_zero, w_br_inv;
  logic            w_br_flag;

`ifndef EXEC_FAST_SHIFT_EN
  logic            r_shift;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_sh;
  logic            w_shift;
  logic [XLEN-1:0] w_sh_next;
`endif

  assign w_onehot = (instr_bus != '0) && ((instr_bus & (instr_bus - 37'd1)) == '0);

  always_comb begin
    w_idx     = '0;
    for (int i = 0; i < 37; i++) begin
      if (instr_bus[i]) w_idx = 6'(i);
    end
    w_op      = OP_ADD;
    w_use_imm = 1'b1;
    w_br      = 1'b0;
    w_br_zero = 1'b0;
    w_br_inv  = 1'b0;
    case (w_idx)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: begin
        w_op      = w_idx[3:0];
        w_use_imm = 1'b0;
      end
      6'd10: w_op = OP_ADD;
      6'd11: w_op = OP_XOR;
      6'd12: w_op = OP_OR;
      6'd13: w_op = OP_AND;
      6'd14: w_op = OP_SLL;
      6'd15: w_op = OP_SRL;
      6'd16: w_op = OP_SRA;
      6'd17: w_op = OP_SLT;
      6'd18: w_op = OP_SLTU;
      6'd19, 6'd20: begin
        w_op      = OP_SUB;
        w_use_imm = 1'b0;
        w_br      = 1'b1;
        w_br_zero = 1'b1;
        w_br_inv  = (w_idx == 6'd20);
      end
      6'd21, 6'd22: begin
        w_op      = OP_SLT;
        w_use_imm = 1'b0;
        w_br      = 1'b1;
        w_br_inv  = (w_idx == 6'd22);
      end
      6'd23, 6'd24: begin
        w_op      = OP_SLTU;
        w_use_imm = 1'b0;
        w_br      = 1'b1;
        w_br_inv  = (w_idx == 6'd24);
      end
      default: ;
    endcase
    // Illegal encodings issue a harmless ADD; their result is forced to 0 on capture.
    if (!w_onehot) begin
      w_op = OP_ADD;
      w_br = 1'b0;
    end
  end

  assign w_br_flag = r_br_zero ? alu_zero : alu_result[0];

`ifndef EXEC_FAST_SHIFT_EN
  assign w_shift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);

  always_comb begin
    w_sh_next = r_sh << 1;
    if (r_op == OP_SRL)      w_sh_next = r_sh >> 1;
    else if (r_op == OP_SRA) w_sh_next = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = OP_ADD;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        alu_a       = r_a;
        alu_b       = r_b;
        alu_op      = r_op;
        w_state_nxt = S_HOLD;
`ifndef EXEC_FAST_SHIFT_EN
        // Serial shifts keep the ALU on ADD so it never sees a shift opcode.
        if (r_shift) begin
          alu_op = OP_ADD;
          if (r_b[4:0] != 5'd0) w_state_nxt = S_SHIFT;
        end
`endif
      end
`ifndef EXEC_FAST_SHIFT_EN
      S_SHIFT: begin
        if (r_cnt == 5'd1) w_state_nxt = S_HOLD;
      end
`endif
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_ADD;
      r_bad     <= 1'b0;
      r_br      <= 1'b0;
      r_br_zero <= 1'b0;
      r_br_inv  <= 1'b0;
      r_result  <= '0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
`ifndef EXEC_FAST_SHIFT_EN
      r_shift   <= 1'b0;
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op      <= w_op;
            r_bad     <= !w_onehot;
            r_br      <= w_br;
            r_br_zero <= w_br_zero;
            r_br_inv  <= w_br_inv;
`ifndef EXEC_FAST_SHIFT_EN
            r_shift   <= w_shift;
`endif
          end
        end
        S_ISSUE: begin
          if (r_bad) begin
            r_result  <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b1;
          end
`ifndef EXEC_FAST_SHIFT_EN
          else if (r_shift) begin
            r_cnt     <= r_b[4:0];
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            if (r_b[4:0] == 5'd0) r_result <= r_a;
          end
`endif
          else begin
            r_result  <= alu_result;
            r_taken   <= r_br & (w_br_flag ^ r_br_inv);
            r_illegal <= 1'b0;
          end
        end
`ifndef EXEC_FAST_SHIFT_EN
        S_SHIFT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_result <= w_sh_next;
        end
`endif
        default: ;
      endcase
    end
  end

  // Operand and shift registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      r_a <= rs1;
      r_b <= w_use_imm ? imm : rs2;
    end
`ifndef EXEC_FAST_SHIFT_EN
    if (r_state == S_ISSUE)      r_sh <= r_a;
    else if (r_state == S_SHIFT) r_sh <= w_sh_next;
`endif
  end

  assign result       = r_result;
  assign branch_taken = r_taken;
  assign illegal      = r_illegal;

endmodule
